// File: rtl/y_run_logger.sv
// rtl/y_run_logger.sv - Logs {timestamp,length} records of each high run of Y into a small FIFO.
// Records drain over a valid/ready port; a run that completes while the FIFO is full is dropped and flagged.
module y_run_logger #(
  parameter int TS_W  = 8,
  parameter int LEN_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Y,
  input  logic                       en,
  input  logic                       ovf_clr,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [TS_W-1:0]            evt_ts,
  output logic [LEN_W-1:0]           evt_len,
  output logic [$clog2(DEPTH):0]     evt_cnt,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SKIP} state_t;

  state_t             state_q, state_d;
  logic [TS_W-1:0]    ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0]    run_ts_q, run_ts_d;
  logic [LEN_W-1:0]   run_len_q, run_len_d;
  logic [TS_W-1:0]    mem_ts_q  [DEPTH];
  logic [TS_W-1:0]    mem_ts_d  [DEPTH];
  logic [LEN_W-1:0]   mem_len_q [DEPTH];
  logic [LEN_W-1:0]   mem_len_d [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               overflow_q, overflow_d;
  logic [TS_W-1:0]    last_ts_q, last_ts_d;
  logic [LEN_W-1:0]   last_len_q, last_len_d;
  logic               push_req, pop, full, do_push, drop;

  always_comb begin
    state_d   = state_q;
    run_ts_d  = run_ts_q;
    run_len_d = run_len_q;
    push_req  = 1'b0;
    ts_cnt_d  = ts_cnt_q + TS_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (Y && en) begin
          state_d   = S_RUN;
          run_ts_d  = ts_cnt_q;
          run_len_d = LEN_W'(1);
        end else if (Y) begin
          state_d = S_SKIP;
        end
      end
      S_SKIP: begin
        if (!Y) state_d = S_IDLE;
      end
      S_RUN: begin
        if (Y) begin
          if (run_len_q != '1) run_len_d = run_len_q + LEN_W'(1);
        end else begin
          push_req = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    evt_valid = (cnt_q != '0);
    full      = (cnt_q == CW'(DEPTH));
    pop       = evt_valid && evt_ready;
    do_push   = push_req && (!full || pop);
    drop      = push_req && full && !pop;

    mem_ts_d  = mem_ts_q;
    mem_len_d = mem_len_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (do_push) begin
      mem_ts_d[wr_ptr_q]  = run_ts_q;
      mem_len_d[wr_ptr_q] = run_len_q;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    overflow_d = drop || (overflow_q && !ovf_clr);

    // Outputs freeze on the last head while empty rather than exposing stale slots.
    evt_ts     = evt_valid ? mem_ts_q[rd_ptr_q]  : last_ts_q;
    evt_len    = evt_valid ? mem_len_q[rd_ptr_q] : last_len_q;
    last_ts_d  = evt_ts;
    last_len_d = evt_len;
  end

  assign evt_cnt  = cnt_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ts_cnt_q   <= '0;
      run_ts_q   <= '0;
      run_len_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      last_ts_q  <= '0;
      last_len_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ts_q[i]  <= '0;
        mem_len_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ts_cnt_q   <= ts_cnt_d;
      run_ts_q   <= run_ts_d;
      run_len_q  <= run_len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      last_ts_q  <= last_ts_d;
      last_len_q <= last_len_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ts_q[i]  <= mem_ts_d[i];
        mem_len_q[i] <= mem_len_d[i];
      end
    end
  end
endmodule

// File: tb/tb_y_run_logger.sv
// tb/tb_y_run_logger.sv - Directed self-checking bench for y_run_logger.
module tb_y_run_logger;
  logic       clk = 1'b0;
  logic       rst, Y, en, ovf_clr, evt_ready;
  logic       evt_valid, overflow;
  logic [7:0] evt_ts;
  logic [3:0] evt_len;
  logic [2:0] evt_cnt;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] ts;
  logic [7:0] rts [5];
  logic [7:0] t0;

  y_run_logger #(.TS_W(8), .LEN_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .Y(Y), .en(en), .ovf_clr(ovf_clr),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_ts(evt_ts),
    .evt_len(evt_len), .evt_cnt(evt_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // ts tracks the counter value the next rising edge will sample.
  task automatic step();
    @(posedge clk);
    #1;
    ts = ts + 8'd1;
  endtask

  task automatic one_run(input int idx);
    rts[idx] = ts;
    Y = 1'b1; step();
    Y = 1'b0; step();
  endtask

  task automatic pop_one();
    evt_ready = 1'b1; step();
    evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Y = 1'b0; en = 1'b1; ovf_clr = 1'b0; evt_ready = 1'b0; ts = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_cnt", evt_cnt, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_len", evt_len, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk); rst = 1'b0; ts = 8'd0;

    // basic run: Y high at ts 3,4
    step(); step(); step();
    Y = 1'b1; step(); step();
    Y = 1'b0; step();
    chk("t1_valid", evt_valid, 1);
    chk("t1_ts", evt_ts, 3);
    chk("t1_len", evt_len, 2);
    chk("t1_cnt", evt_cnt, 1);
    pop_one();
    chk("t1_pop_valid", evt_valid, 0);
    chk("t1_pop_cnt", evt_cnt, 0);

    // saturation
    t0 = ts;
    Y = 1'b1; repeat (20) step();
    Y = 1'b0; step();
    chk("t2_ts", evt_ts, t0);
    chk("t2_len", evt_len, 15);
    step();
    chk("t2_single", evt_cnt, 1);
    pop_one();
    chk("t2_empty", evt_cnt, 0);

    // overflow
    for (int i = 0; i < 5; i++) one_run(i);
    chk("t3_cnt", evt_cnt, 4);
    chk("t3_ovf", overflow, 1);
    chk("t3_head_ts", evt_ts, rts[0]);
    chk("t3_head_len", evt_len, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain%0d_ts", i), evt_ts, rts[i]);
      chk($sformatf("t3_drain%0d_valid", i), evt_valid, 1);
      pop_one();
    end
    chk("t3_drained", evt_cnt, 0);
    chk("t3_drained_valid", evt_valid, 0);

    // push and pop on the same edge while full
    for (int i = 0; i < 4; i++) one_run(i);
    chk("t4_full", evt_cnt, 4);
    rts[4] = ts;
    Y = 1'b1; step();
    Y = 1'b0; evt_ready = 1'b1; step(); evt_ready = 1'b0;
    chk("t4_cnt", evt_cnt, 4);
    chk("t4_ovf", overflow, 0);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("t4_drain%0d_ts", i), evt_ts, rts[i]);
      pop_one();
    end
    chk("t4_drained", evt_cnt, 0);

    // en low at run start suppresses the whole run
    en = 1'b0; Y = 1'b1; step();
    en = 1'b1; step(); step();
    Y = 1'b0; step(); step();
    chk("t5_skip_cnt", evt_cnt, 0);
    chk("t5_skip_valid", evt_valid, 0);
    t0 = ts;
    Y = 1'b1; step(); step();
    Y = 1'b0; step();
    chk("t5_ts", evt_ts, t0);
    chk("t5_len", evt_len, 2);
    pop_one();

    // timestamp wrap
    for (int i = 0; i < 300 && ts != 8'd254; i++) step();
    chk("t6_reach254", ts, 254);
    Y = 1'b1; repeat (4) step();
    Y = 1'b0; step();
    chk("t6_ts", evt_ts, 254);
    chk("t6_len", evt_len, 4);
    pop_one();
    t0 = ts;
    Y = 1'b1; step();
    Y = 1'b0; step();
    chk("t6_wrap_ts", evt_ts, t0);
    chk("t6_wrap_len", evt_len, 1);
    pop_one();

    // reset mid-run
    Y = 1'b1; step(); step();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_cnt", evt_cnt, 0);
    Y = 1'b0;
    @(negedge clk); rst = 1'b0; ts = 8'd0;
    step(); step();
    chk("t6_norec_cnt", evt_cnt, 0);
    chk("t6_norec_valid", evt_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
